// File: rtl/sme_pkg.sv
// Shared definitions for the string-matching engine, its host driver and benches.
package sme_pkg;

  localparam int CHAR_W    = 8;
  localparam int STR_MAX   = 32;
  localparam int PAT_MAX   = 8;
  localparam int STR_IDX_W = 5;
  localparam int PAT_IDX_W = 3;
  // Wide enough for TIMEOUT up to 1023 and for the holdoff count.
  localparam int TMR_W     = 10;

  // Pattern metacharacters understood by the engine.
  localparam logic [CHAR_W-1:0] CH_CARET  = 8'h5E;
  localparam logic [CHAR_W-1:0] CH_DOLLAR = 8'h24;
  localparam logic [CHAR_W-1:0] CH_DOT    = 8'h2E;
  localparam logic [CHAR_W-1:0] CH_STAR   = 8'h2A;
  localparam logic [CHAR_W-1:0] CH_SPACE  = 8'h20;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND_STR,
    ST_SEND_PAT,
    ST_WAIT,
    ST_RESULT,
    ST_HOLD
  } state_e;

  function automatic logic is_meta(input logic [CHAR_W-1:0] c);
    return (c == CH_CARET) || (c == CH_DOLLAR) || (c == CH_DOT) || (c == CH_STAR);
  endfunction

endpackage

// File: rtl/sme_drv_buf.sv
// String (32x8) and pattern (8x8) register files: one host write port,
// one combinational read port selected by rd_sel.
module sme_drv_buf
  import sme_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wr_en,
  input  logic                 wr_sel,
  input  logic [STR_IDX_W-1:0] wr_addr,
  input  logic [CHAR_W-1:0]    wr_data,
  input  logic                 rd_sel,
  input  logic [STR_IDX_W-1:0] rd_addr,
  output logic [CHAR_W-1:0]    rd_data
);

  logic [CHAR_W-1:0] str_mem_q [STR_MAX];
  logic [CHAR_W-1:0] pat_mem_q [PAT_MAX];

  // Host writes; both buffers cleared on reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < STR_MAX; i++) str_mem_q[i] <= '0;
      for (int i = 0; i < PAT_MAX; i++) pat_mem_q[i] <= '0;
    end else if (wr_en) begin
      if (wr_sel) pat_mem_q[wr_addr[PAT_IDX_W-1:0]] <= wr_data;
      else        str_mem_q[wr_addr]                <= wr_data;
    end
  end

  // Read mux; pattern uses only the low index bits.
  always_comb begin
    rd_data = rd_sel ? pat_mem_q[rd_addr[PAT_IDX_W-1:0]] : str_mem_q[rd_addr];
  end

endmodule

// File: rtl/sme_driver.sv
// Host-side transmitter for the string-matching engine.
// Optional feature macro: SME_DRV_TIMEOUT_EN (WAIT abort after TIMEOUT cycles).
//
// state    | meaning
// IDLE     | ready; start latches lengths and launches a job
// SEND_STR | streaming string chars on chardata with isstring
// SEND_PAT | streaming pattern chars on chardata with ispattern
// WAIT     | bus quiet, waiting for the engine's valid strobe
// RESULT   | done pulse with captured result
// HOLD     | HOLDOFF quiet cycles before the next job
module sme_driver
  import sme_pkg::*;
#(
  parameter int TIMEOUT = 256,
  parameter int HOLDOFF = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wr_en,
  input  logic                 wr_sel,
  input  logic [4:0]           wr_addr,
  input  logic [7:0]           wr_data,
  input  logic                 start,
  input  logic                 new_string,
  input  logic [4:0]           str_len_m1,
  input  logic [2:0]           pat_len_m1,
  output logic [7:0]           chardata,
  output logic                 isstring,
  output logic                 ispattern,
  input  logic                 valid,
  input  logic                 match,
  input  logic [4:0]           match_index,
  output logic                 busy,
  output logic                 done,
  output logic                 res_match,
  output logic [4:0]           res_index,
  output logic                 timeout
);

  state_e                 state_q, state_d;
  logic [STR_IDX_W-1:0]   k_q, k_d;
  logic [TMR_W-1:0]       tmr_q, tmr_d;
  logic [STR_IDX_W-1:0]   str_len_q, str_len_d;
  logic [PAT_IDX_W-1:0]   pat_len_q, pat_len_d;
  logic [CHAR_W-1:0]      chardata_q, chardata_d;
  logic                   isstring_q, isstring_d;
  logic                   ispattern_q, ispattern_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   res_match_q, res_match_d;
  logic [STR_IDX_W-1:0]   res_index_q, res_index_d;
`ifdef SME_DRV_TIMEOUT_EN
  logic                   timeout_q, timeout_d;
`endif

  logic                   buf_rd_sel;
  logic [STR_IDX_W-1:0]   buf_rd_addr;
  logic [CHAR_W-1:0]      buf_rd_data;

  // Buffers are frozen while a job is running.
  sme_drv_buf u_buf (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en && !busy_q),
    .wr_sel  (wr_sel),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_sel  (buf_rd_sel),
    .rd_addr (buf_rd_addr),
    .rd_data (buf_rd_data)
  );

  // Next-state logic; k_d/strobe_d describe the char that will be on the bus next cycle.
  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    tmr_d       = tmr_q;
    str_len_d   = str_len_q;
    pat_len_d   = pat_len_q;
    isstring_d  = 1'b0;
    ispattern_d = 1'b0;
    done_d      = 1'b0;
    res_match_d = res_match_q;
    res_index_d = res_index_q;
`ifdef SME_DRV_TIMEOUT_EN
    timeout_d   = timeout_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start && !busy_q) begin
          str_len_d = str_len_m1;
          pat_len_d = pat_len_m1;
          k_d       = '0;
          if (new_string) begin
            state_d    = ST_SEND_STR;
            isstring_d = 1'b1;
          end else begin
            state_d     = ST_SEND_PAT;
            ispattern_d = 1'b1;
          end
        end
      end
      ST_SEND_STR: begin
        if (k_q == str_len_q) begin
          state_d     = ST_SEND_PAT;
          k_d         = '0;
          ispattern_d = 1'b1;
        end else begin
          k_d        = k_q + 1'b1;
          isstring_d = 1'b1;
        end
      end
      ST_SEND_PAT: begin
        if (k_q == {2'b00, pat_len_q}) begin
          state_d = ST_WAIT;
          k_d     = '0;
          tmr_d   = TMR_W'(TIMEOUT - 1);
        end else begin
          k_d         = k_q + 1'b1;
          ispattern_d = 1'b1;
        end
      end
      ST_WAIT: begin
        if (valid) begin
          state_d     = ST_RESULT;
          done_d      = 1'b1;
          res_match_d = match;
          res_index_d = match_index;
`ifdef SME_DRV_TIMEOUT_EN
          timeout_d   = 1'b0;
        end else if (tmr_q == '0) begin
          state_d     = ST_RESULT;
          done_d      = 1'b1;
          res_match_d = 1'b0;
          res_index_d = '0;
          timeout_d   = 1'b1;
        end else begin
          tmr_d = tmr_q - 1'b1;
`endif
        end
      end
      ST_RESULT: begin
        if (HOLDOFF == 0) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_HOLD;
          tmr_d   = TMR_W'(HOLDOFF - 1);
        end
      end
      ST_HOLD: begin
        if (tmr_q == '0) state_d = ST_IDLE;
        else             tmr_d   = tmr_q - 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  assign buf_rd_sel  = ispattern_d;
  assign buf_rd_addr = k_d;

  // Bus data is forced to zero whenever neither strobe is active.
  always_comb begin
    chardata_d = (isstring_d || ispattern_d) ? buf_rd_data : '0;
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      k_q         <= '0;
      tmr_q       <= '0;
      str_len_q   <= '0;
      pat_len_q   <= '0;
      chardata_q  <= '0;
      isstring_q  <= 1'b0;
      ispattern_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      res_match_q <= 1'b0;
      res_index_q <= '0;
`ifdef SME_DRV_TIMEOUT_EN
      timeout_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      tmr_q       <= tmr_d;
      str_len_q   <= str_len_d;
      pat_len_q   <= pat_len_d;
      chardata_q  <= chardata_d;
      isstring_q  <= isstring_d;
      ispattern_q <= ispattern_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      res_match_q <= res_match_d;
      res_index_q <= res_index_d;
`ifdef SME_DRV_TIMEOUT_EN
      timeout_q   <= timeout_d;
`endif
    end
  end

  assign chardata  = chardata_q;
  assign isstring  = isstring_q;
  assign ispattern = ispattern_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign res_match = res_match_q;
  assign res_index = res_index_q;
`ifdef SME_DRV_TIMEOUT_EN
  assign timeout   = timeout_q;
`else
  assign timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_sme_driver.sv
// Scoreboard bench for sme_driver: the driver pushes the expected character
// stream and result, a negedge monitor pops and compares.
module tb_sme_driver;
  import sme_pkg::*;

  localparam int TO = 16;
  localparam int HO = 2;

  logic       clk, reset;
  logic       wr_en, wr_sel;
  logic [4:0] wr_addr;
  logic [7:0] wr_data;
  logic       start, new_string;
  logic [4:0] str_len_m1;
  logic [2:0] pat_len_m1;
  logic [7:0] chardata;
  logic       isstring, ispattern;
  logic       valid, match;
  logic [4:0] match_index;
  logic       busy, done, res_match, timeout;
  logic [4:0] res_index;

  sme_driver #(.TIMEOUT(TO), .HOLDOFF(HO)) dut (
    .clk(clk), .reset(reset),
    .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .new_string(new_string),
    .str_len_m1(str_len_m1), .pat_len_m1(pat_len_m1),
    .chardata(chardata), .isstring(isstring), .ispattern(ispattern),
    .valid(valid), .match(match), .match_index(match_index),
    .busy(busy), .done(done), .res_match(res_match), .res_index(res_index),
    .timeout(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  function automatic void chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  typedef struct { int cyc; bit s; bit p; int ch; } char_t;
  typedef struct { int cyc; bit m; int idx; bit to; } res_t;
  char_t cq[$];
  res_t  rq[$];

  // Reference model of the host buffers.
  logic [7:0] m_str[32];
  logic [7:0] m_pat[8];
  bit mon_en = 1'b0;

  // Monitor: every bus char and every done pulse must match the scoreboard head.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("strobe_excl", int'(isstring & ispattern), 0);
      if (isstring || ispattern) begin
        if (cq.size() == 0) chk("unexpected_char", cq.size(), 1);
        else begin
          char_t e;
          e = cq.pop_front();
          chk("char_cycle", cyc, e.cyc);
          chk("isstring", int'(isstring), int'(e.s));
          chk("ispattern", int'(ispattern), int'(e.p));
          chk("chardata", int'(chardata), e.ch);
        end
      end else begin
        chk("idle_chardata", int'(chardata), 0);
      end
      if (done) begin
        if (rq.size() == 0) chk("unexpected_done", rq.size(), 1);
        else begin
          res_t r;
          r = rq.pop_front();
          chk("done_cycle", cyc, r.cyc);
          chk("res_match", int'(res_match), int'(r.m));
          chk("res_index", int'(res_index), r.idx);
          chk("timeout", int'(timeout), int'(r.to));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic host_write(input bit sel, input int addr, input int d);
    wr_en = 1'b1; wr_sel = sel; wr_addr = 5'(addr); wr_data = 8'(d);
    tick();
    wr_en = 1'b0;
    if (sel) m_pat[addr % 8] = 8'(d);
    else     m_str[addr % 32] = 8'(d);
  endtask

  task automatic noise(input bit en, input bit allow_valid);
    if (en) begin
      start       = ($urandom_range(0, 3) == 0);
      new_string  = 1'($urandom);
      str_len_m1  = 5'($urandom);
      pat_len_m1  = 3'($urandom);
      wr_en       = 1'($urandom);
      wr_sel      = 1'($urandom);
      wr_addr     = 5'($urandom);
      wr_data     = 8'($urandom);
      valid       = allow_valid & 1'($urandom);
      match       = 1'($urandom);
      match_index = 5'($urandom);
    end
  endtask

  task automatic quiet();
    start = 1'b0; wr_en = 1'b0; valid = 1'b0;
  endtask

  // One job: issue start, predict stream/result, optionally disturb the DUT while busy.
  task automatic run_job(input bit ns, input int slm1, input int plm1, input int vdel,
                         input bit withhold, input bit mt, input int idx, input bit nz);
    int s, n, ws, v, d;
    s = cyc;
    start = 1'b1; new_string = ns; str_len_m1 = 5'(slm1); pat_len_m1 = 3'(plm1);
    n = 0;
    if (ns) begin
      for (int k = 0; k <= slm1; k++) cq.push_back('{s + 1 + k, 1'b1, 1'b0, int'(m_str[k])});
      n = slm1 + 1;
    end
    for (int k = 0; k <= plm1; k++) cq.push_back('{s + 1 + n + k, 1'b0, 1'b1, int'(m_pat[k])});
    n += plm1 + 1;
    ws = s + n + 1;
    if (withhold) begin
      v = -1;
      d = ws + TO;
      rq.push_back('{d, 1'b0, 0, 1'b1});
    end else begin
      v = ws + vdel;
      d = v + 1;
      rq.push_back('{d, mt, idx, 1'b0});
    end
    tick();
    quiet();
    chk("busy_after_start", int'(busy), 1);
    while (cyc < (withhold ? d : v)) begin
      noise(nz, cyc <= s + n);
      tick();
    end
    quiet();
    if (!withhold) begin
      valid = 1'b1; match = mt; match_index = 5'(idx);
      tick();
      valid = 1'b0;
    end
    while (cyc < d + 1 + HO) begin
      if (cyc == d + HO) chk("busy_hold", int'(busy), 1);
      noise(nz, 1'b1);
      tick();
    end
    quiet();
    chk("busy_release", int'(busy), 0);
    chk("res_hold_match", int'(res_match), withhold ? 0 : int'(mt));
    chk("res_hold_index", int'(res_index), withhold ? 0 : idx);
    chk("stream_drained", cq.size(), 0);
    chk("result_drained", rq.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    string s1, p1;
    reset = 1'b0;
    wr_en = 0; wr_sel = 0; wr_addr = 0; wr_data = 0;
    start = 0; new_string = 0; str_len_m1 = 0; pat_len_m1 = 0;
    valid = 0; match = 0; match_index = 0;
    for (int i = 0; i < 32; i++) m_str[i] = 8'h00;
    for (int i = 0; i < 8; i++)  m_pat[i] = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_chardata", int'(chardata), 0);
    chk("rst_isstring", int'(isstring), 0);
    chk("rst_ispattern", int'(ispattern), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_res_match", int'(res_match), 0);
    chk("rst_res_index", int'(res_index), 0);
    chk("rst_timeout", int'(timeout), 0);
    reset = 1'b1;
    tick();
    mon_en = 1'b1;

    // "abc def" / "def", engine reports a match at 4.
    s1 = "abc def";
    p1 = "def";
    for (int i = 0; i < 7; i++) host_write(1'b0, i, int'(s1[i]));
    for (int i = 0; i < 3; i++) host_write(1'b1, i, int'(p1[i]));
    run_job(1'b1, 6, 2, 3, 1'b0, 1'b1, 4, 1'b0);

    // Pattern-only job with a metacharacter.
    host_write(1'b1, 0, int'(CH_CARET));
    host_write(1'b1, 1, 8'h61);
    host_write(1'b1, 2, 8'h62);
    run_job(1'b0, 6, 2, 0, 1'b0, 1'b0, 0, 1'b1);

    // Maximum lengths, random contents, then an immediate back-to-back start.
    for (int i = 0; i < 32; i++) host_write(1'b0, i, int'($urandom_range(0, 255)));
    for (int i = 0; i < 8; i++)  host_write(1'b1, i, int'($urandom_range(1, 255)));
    run_job(1'b1, 31, 7, 5, 1'b0, 1'b1, 31, 1'b1);
    run_job(1'b0, 0, 7, 1, 1'b0, 1'b0, 17, 1'b1);

    // Randomized jobs.
    for (int j = 0; j < 15; j++) begin
      int nw;
      int vmax;
      nw = $urandom_range(0, 4);
      for (int w = 0; w < nw; w++) begin
        bit sel;
        sel = 1'($urandom);
        host_write(sel, sel ? $urandom_range(0, 7) : $urandom_range(0, 31), $urandom_range(0, 255));
      end
`ifdef SME_DRV_TIMEOUT_EN
      vmax = TO - 1;
`else
      vmax = 40;
`endif
      run_job(1'($urandom), $urandom_range(0, 31), $urandom_range(0, 7),
              $urandom_range(0, vmax), 1'b0, 1'($urandom), $urandom_range(0, 31), 1'b1);
    end

`ifdef SME_DRV_TIMEOUT_EN
    // Engine never answers: abort after TO wait cycles, late valid ignored.
    run_job(1'b1, 2, 1, 0, 1'b1, 1'b0, 0, 1'b1);
`endif

    // Reset in the middle of the pattern phase.
    for (int i = 0; i < 4; i++) host_write(1'b0, i, $urandom_range(1, 255));
    for (int i = 0; i < 8; i++) host_write(1'b1, i, $urandom_range(1, 255));
    begin
      int s;
      s = cyc;
      start = 1'b1; new_string = 1'b1; str_len_m1 = 5'd3; pat_len_m1 = 3'd7;
      for (int k = 0; k < 4; k++) cq.push_back('{s + 1 + k, 1'b1, 1'b0, int'(m_str[k])});
      for (int k = 0; k < 8; k++) cq.push_back('{s + 5 + k, 1'b0, 1'b1, int'(m_pat[k])});
      tick();
      start = 1'b0;
      while (cyc < s + 7) tick();
      chk("pre_rst_ispattern", int'(ispattern), 1);
      #2;
      mon_en = 1'b0;
      reset = 1'b0;
      #1;
      chk("mid_rst_isstring", int'(isstring), 0);
      chk("mid_rst_ispattern", int'(ispattern), 0);
      chk("mid_rst_chardata", int'(chardata), 0);
      chk("mid_rst_busy", int'(busy), 0);
      chk("mid_rst_done", int'(done), 0);
      cq.delete();
      rq.delete();
      for (int i = 0; i < 32; i++) m_str[i] = 8'h00;
      for (int i = 0; i < 8; i++)  m_pat[i] = 8'h00;
      repeat (2) begin
        tick();
        chk("rst_low_done", int'(done), 0);
      end
      reset = 1'b1;
      mon_en = 1'b1;
      repeat (6) tick();
      chk("post_rst_busy", int'(busy), 0);
    end

    // Buffers were cleared by reset: the stream must be all zero characters.
    run_job(1'b1, 4, 3, 2, 1'b0, 1'b1, 9, 1'b0);

    repeat (3) tick();
    chk("final_char_queue", cq.size(), 0);
    chk("final_res_queue", rq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
